// File: rtl/riscv_hazard_pkg.sv
// Shared encodings and state type for the memory-wait hazard unit.
package riscv_hazard_pkg;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_W           = 2'b01;
  localparam logic [1:0] FWD_M           = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Wide enough for the largest legal timeout (255).
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EXECUTE source operand; MEMORY ACCESS beats WRITEBACK.
module hazard_fwd_sel
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  output logic [1:0]            fwd_sel_c
);

  // Priority compare against the two younger writers; x0 never forwards.
  always_comb begin
    fwd_sel_c = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel_c = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel_c = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mw.sv
// Hazard unit with variable-latency data memory support.
// Optional performance counters: define HAZARD_PERF_CNT_EN.
module hazard_unit_mw
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [WAIT_CNT_W-1:0] TMO = WAIT_CNT_W'(MEM_TIMEOUT);

  logic                  mem_stall;
  logic                  lw_stall;
  hz_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_inc;
  logic                  mem_timeout_q, mem_timeout_d;
  logic                  tmo_hit;

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e(Rs1E), .reg_write_m(RegWriteM), .rd_m(RdM),
    .reg_write_w(RegWriteW), .rd_w(RdW), .fwd_sel_c(ForwardAE)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e(Rs2E), .reg_write_m(RegWriteM), .rd_m(RdM),
    .reg_write_w(RegWriteW), .rd_w(RdW), .fwd_sel_c(ForwardBE)
  );

  // Stall/flush priority: an unacknowledged memory access freezes everything
  // and defers branch flush and load-use bubble until release.
  always_comb begin
    mem_stall = MemReqM && !MemReadyM;
    lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    StallF    = mem_stall || lw_stall;
    StallD    = mem_stall || lw_stall;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushW    = mem_stall;
    FlushD    = !mem_stall && PCSrcE;
    FlushE    = !mem_stall && (lw_stall || PCSrcE);
  end

  // Wait-state register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Count of consecutive stall cycles including this one, saturating.
  always_comb begin
    wait_inc = WAIT_CNT_W'(1);
    if (state_q != RUN) begin
      wait_inc = (wait_cnt_q >= TMO) ? TMO : (wait_cnt_q + WAIT_CNT_W'(1));
    end
    tmo_hit = mem_stall && (wait_inc == TMO);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_stall) state_d = tmo_hit ? TIMEOUT : MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_d = RUN;
                else if (tmo_hit) state_d = TIMEOUT;
      TIMEOUT:  if (!mem_stall) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // FSM-controlled outputs: wait counter reload/increment and timeout set.
  always_comb begin
    wait_cnt_d    = mem_stall ? wait_inc : '0;
    mem_timeout_d = mem_timeout_q || tmo_hit;
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((StallF || StallD || StallE || StallM) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if ((FlushD || FlushE) && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mw.sv
// Self-checking bench for hazard_unit_mw (timeout configured to 4 cycles).
module tb_hazard_unit_mw;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_unit_mw #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RdM(RdM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RegWriteW(RegWriteW), .RdW(RdW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: length of the current run of frozen cycles, sticky flag,
  // and plain event tallies.
  int     run_len = 0;
  bit     m_to    = 1'b0;
  longint m_stall = 0;
  longint m_flush = 0;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc, rwm;
    logic [4:0] rdm;
    logic       mreq, mrdy, rww;
    logic [4:0] rdw;
    logic       e_sfd, e_sem, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ms_ref();
    return MemReqM && !MemReadyM;
  endfunction

  function automatic bit lw_ref();
    return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  task automatic check_comb();
    bit ms, lw;
    ms = ms_ref();
    lw = lw_ref();
    chk("StallF", StallF, ms || lw);
    chk("StallD", StallD, ms || lw);
    chk("StallE", StallE, ms);
    chk("StallM", StallM, ms);
    chk("FlushW", FlushW, ms);
    chk("FlushD", FlushD, !ms && PCSrcE);
    chk("FlushE", FlushE, !ms && (lw || PCSrcE));
    chk("ForwardAE", ForwardAE, fwd_ref(Rs1E));
    chk("ForwardBE", ForwardBE, fwd_ref(Rs2E));
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    bit ms, lw;
    #1;
    check_comb();
    ms = ms_ref();
    lw = lw_ref();
    @(posedge clk);
    if (reset) begin
      run_len = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      run_len = ms ? run_len + 1 : 0;
      if (run_len >= TMO) m_to = 1'b1;
      if (ms || lw) m_stall++;
      if (!ms && (PCSrcE || lw)) m_flush++;
    end
    #1;
    chk("mem_timeout", mem_timeout, m_to);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count", flush_count, m_flush);
`else
    chk("stall_cycles", stall_cycles, 0);
    chk("flush_count", flush_count, 0);
`endif
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; MemReqM = 0; MemReadyM = 0;
    RegWriteW = 0;
  endtask

  task automatic stall_cycles_n(input int n);
    for (int i = 0; i < n; i++) begin
      MemReqM = 1; MemReadyM = 0;
      tick();
    end
  endtask

  initial begin
    // rs1d rs2d rs1e rs2e rde rsrc pc rwm rdm mreq mrdy rww rdw | sfd sem fd fe fa fb
    vecs[0]  = '{0,0,5,3,0,0,0,1,5,0,0,1,5, 0,0,0,0,2'b10,2'b00};
    vecs[1]  = '{0,0,0,0,0,0,0,1,0,0,0,1,0, 0,0,0,0,2'b00,2'b00};
    vecs[2]  = '{0,0,6,6,0,0,0,1,7,0,0,1,6, 0,0,0,0,2'b01,2'b01};
    vecs[3]  = '{0,0,6,6,0,0,0,0,6,0,0,1,6, 0,0,0,0,2'b01,2'b01};
    vecs[4]  = '{0,7,0,0,7,1,0,0,0,0,0,0,0, 1,0,0,1,2'b00,2'b00};
    vecs[5]  = '{0,7,0,0,7,1,1,0,0,0,0,0,0, 1,0,1,1,2'b00,2'b00};
    vecs[6]  = '{0,0,0,0,0,1,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00};
    vecs[7]  = '{7,0,0,0,7,2,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00};
    vecs[8]  = '{7,0,0,0,7,1,1,0,0,1,0,0,0, 1,1,0,0,2'b00,2'b00};
    vecs[9]  = '{0,0,0,0,0,0,1,0,0,1,1,0,0, 0,0,1,1,2'b00,2'b00};
    vecs[10] = '{0,0,3,3,0,0,0,1,3,0,0,0,3, 0,0,0,0,2'b10,2'b10};

    idle();
    reset = 1;
    tick();
    tick();
    chk("reset_timeout", mem_timeout, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    reset = 0;

    // Table-driven combinational vectors.
    foreach (vecs[k]) begin
      Rs1D = vecs[k].rs1d; Rs2D = vecs[k].rs2d; Rs1E = vecs[k].rs1e;
      Rs2E = vecs[k].rs2e; RdE = vecs[k].rde; ResultSrcE = vecs[k].rsrc;
      PCSrcE = vecs[k].pcsrc; RegWriteM = vecs[k].rwm; RdM = vecs[k].rdm;
      MemReqM = vecs[k].mreq; MemReadyM = vecs[k].mrdy;
      RegWriteW = vecs[k].rww; RdW = vecs[k].rdw;
      #1;
      chk($sformatf("vec%0d_StallF", k), StallF, vecs[k].e_sfd);
      chk($sformatf("vec%0d_StallD", k), StallD, vecs[k].e_sfd);
      chk($sformatf("vec%0d_StallM", k), StallM, vecs[k].e_sem);
      chk($sformatf("vec%0d_FlushW", k), FlushW, vecs[k].e_sem);
      chk($sformatf("vec%0d_FlushD", k), FlushD, vecs[k].e_fd);
      chk($sformatf("vec%0d_FlushE", k), FlushE, vecs[k].e_fe);
      chk($sformatf("vec%0d_FwdA", k), ForwardAE, vecs[k].e_fa);
      chk($sformatf("vec%0d_FwdB", k), ForwardBE, vecs[k].e_fb);
      tick();
    end

    // Three-cycle wait then acknowledge: no timeout.
    idle(); reset = 1; tick(); reset = 0;
    stall_cycles_n(3);
    MemReqM = 1; MemReadyM = 1;
    #1; chk("wait3_release_StallM", StallM, 0);
    tick();
    idle(); tick();
    chk("wait3_no_timeout", mem_timeout, 0);

    // Back-to-back waits of 3 cycles each must not accumulate toward timeout.
    stall_cycles_n(3);
    MemReqM = 0; MemReadyM = 0; tick();
    stall_cycles_n(3);
    idle(); tick();
    chk("b2b_no_timeout", mem_timeout, 0);

    // Six-cycle wait: timeout sets at the end of the 4th, sticks, reset clears.
    stall_cycles_n(3);
    chk("tmo_before", mem_timeout, 0);
    stall_cycles_n(1);
    chk("tmo_at_4", mem_timeout, 1);
    stall_cycles_n(2);
    idle(); tick(); tick();
    chk("tmo_sticky", mem_timeout, 1);
    reset = 1; tick(); reset = 0;
    chk("tmo_reset_clear", mem_timeout, 0);

    // Branch taken during a freeze is deferred to the release cycle.
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    #1;
    chk("defer_FlushD_stalled", FlushD, 0);
    chk("defer_FlushE_stalled", FlushE, 0);
    tick(); tick();
    MemReadyM = 1;
    #1;
    chk("defer_FlushD_release", FlushD, 1);
    chk("defer_FlushE_release", FlushE, 1);
    tick();
    idle();

    // Three-cycle freeze plus one load-use stall, then reset mid-wait.
    reset = 1; tick(); reset = 0;
    stall_cycles_n(3);
    MemReqM = 0; ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; tick();
    idle(); tick();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_4", stall_cycles, 4);
    chk("perf_flush_1", flush_count, 1);
`else
    chk("perf_stall_tied", stall_cycles, 0);
`endif
    stall_cycles_n(2);
    reset = 1; MemReqM = 1; tick(); reset = 0;
    chk("midwait_reset_cnt", stall_cycles, 0);
    // A stall right after reset must restart from one: three more stay clear.
    stall_cycles_n(3);
    chk("midwait_reset_run", mem_timeout, 0);
    idle(); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      Rs1D       = AW'($urandom_range(0, 3));
      Rs2D       = AW'($urandom_range(0, 3));
      Rs1E       = AW'($urandom_range(0, 3));
      Rs2E       = AW'($urandom_range(0, 3));
      RdE        = AW'($urandom_range(0, 3));
      RdM        = AW'($urandom_range(0, 3));
      RdW        = AW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom_range(0, 9) < 7);
      MemReadyM  = ($urandom_range(0, 9) < 3);
      tick();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
